// File: rtl/ssd_pkg.sv
// Shared constants and helpers for the seven-segment display path.
// Segment patterns are active-low, bit6..0 = g..a.
package ssd_pkg;

    localparam int SEG_W = 7;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    // Patterns shared with the per-nibble decoder table
    localparam logic [SEG_W-1:0] SEG_0 = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1 = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2 = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3 = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4 = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5 = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6 = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7 = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8 = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9 = 7'b0010000;

    // Active-low one-hot anode vector; callers cast down to their digit count.
    function automatic logic [31:0] onehot_n(input logic [31:0] idx);
        onehot_n = ~(32'd1 << idx);
    endfunction

endpackage

// File: rtl/ssd_tick.sv
// Slot timer: counts 0..REFRESH_DIV-1, flags the last cycle of a slot and
// the leading guard cycles during which all anodes stay dark.
module ssd_tick
    import ssd_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    output logic [$clog2(REFRESH_DIV)-1:0] div_cnt,
    output logic                           tick,
    output logic                           guard
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_CNT = CNT_W'(GUARD);

    logic [CNT_W-1:0] div_cnt_reg;
    logic [CNT_W-1:0] div_cnt_next;

    always_comb begin
        div_cnt_next = div_cnt_reg + 1'b1;
        if (div_cnt_reg == LAST_CNT) begin
            div_cnt_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_reg <= '0;
        end else begin
            div_cnt_reg <= div_cnt_next;
        end
    end

    assign div_cnt = div_cnt_reg;
    assign tick    = (div_cnt_reg == LAST_CNT);
    assign guard   = (div_cnt_reg < GUARD_CNT);

endmodule

// File: rtl/ssd_scan.sv
// Time-multiplexed 4-digit common-anode display driver. New frames are staged
// on load and committed to the displayed shadow copy only at frame wrap.
module ssd_scan
    import ssd_pkg::*;
#(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [SEG_W*N_DIGITS-1:0] seg_in,
    input  logic                      load,
    output logic                      load_ack,
    output logic                      frame_done,
    output logic [N_DIGITS-1:0]       an,
    output logic [SEG_W-1:0]          seg
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int DIG_W = $clog2(N_DIGITS);
    localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [DIG_W-1:0] LAST_DIGIT = DIG_W'(N_DIGITS - 1);

    logic [CNT_W-1:0]    div_cnt;
    logic                tick;
    logic                guard;

    logic [DIG_W-1:0]    digit_reg;
    logic [DIG_W-1:0]    digit_next;
    logic                pending_reg;
    logic                pending_next;
    logic [SEG_W-1:0]    staging_reg [N_DIGITS];
    logic [SEG_W-1:0]    shadow_reg  [N_DIGITS];

    logic [N_DIGITS-1:0] an_reg;
    logic [SEG_W-1:0]    seg_reg;
    logic                load_ack_reg;
    logic                frame_done_reg;

    logic                wrap;
    logic                commit;
    logic [N_DIGITS-1:0] an_sel;

    ssd_tick #(
        .REFRESH_DIV (REFRESH_DIV),
        .GUARD       (GUARD)
    ) u_tick (
        .clk     (clk),
        .reset   (reset),
        .div_cnt (div_cnt),
        .tick    (tick),
        .guard   (guard)
    );

    // Frame end is the last cycle of the last digit's slot.
    assign wrap   = (div_cnt == LAST_CNT) && (digit_reg == LAST_DIGIT);
    assign commit = wrap && pending_reg;
    assign an_sel = N_DIGITS'(onehot_n(32'(digit_reg)));

    always_comb begin
        digit_next = digit_reg;
        if (tick) begin
            digit_next = wrap ? '0 : digit_reg + 1'b1;
        end
    end

    // A load in the commit cycle keeps the request alive for the next frame.
    always_comb begin
        pending_next = pending_reg;
        if (load) begin
            pending_next = 1'b1;
        end else if (commit) begin
            pending_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            digit_reg   <= '0;
            pending_reg <= 1'b0;
        end else begin
            digit_reg   <= digit_next;
            pending_reg <= pending_next;
        end
    end

    generate
        for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
            always_ff @(posedge clk) begin
                if (reset) begin
                    staging_reg[gi] <= SEG_BLANK;
                    shadow_reg[gi]  <= SEG_BLANK;
                end else begin
                    if (load) begin
                        staging_reg[gi] <= seg_in[SEG_W*gi +: SEG_W];
                    end
                    if (commit) begin
                        shadow_reg[gi] <= staging_reg[gi];
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            an_reg         <= '1;
            seg_reg        <= SEG_BLANK;
            load_ack_reg   <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            an_reg         <= guard ? '1 : an_sel;
            seg_reg        <= guard ? SEG_BLANK : shadow_reg[digit_reg];
            load_ack_reg   <= commit;
            frame_done_reg <= wrap;
        end
    end

    assign an         = an_reg;
    assign seg        = seg_reg;
    assign load_ack   = load_ack_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_ssd_scan.sv
// Self-checking bench for ssd_scan (N_DIGITS=4, REFRESH_DIV=4, GUARD=1):
// every cycle is compared against a slot/frame model built from cycle arithmetic.
module tb_ssd_scan;

    localparam int N = 4;
    localparam int R = 4;
    localparam int G = 1;
    localparam int F = N * R;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          load = 1'b0;
    logic [27:0]   seg_in = '0;
    logic          load_ack;
    logic          frame_done;
    logic [3:0]    an;
    logic [6:0]    seg;

    int checks = 0;
    int errors = 0;

    // reference model state
    int         m_n;
    bit         m_pending;
    logic [6:0] m_stag [N];
    logic [6:0] m_shad [N];
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_ack;
    logic       e_fd;

    int         ack_count;
    int         bad_seen;
    logic [6:0] cap [N];

    typedef struct {
        int         k;
        logic [3:0] an;
        logic [6:0] seg;
        logic       fd;
    } vec_t;
    vec_t tbl [10];

    ssd_scan #(
        .N_DIGITS    (N),
        .REFRESH_DIV (R),
        .GUARD       (G)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .seg_in     (seg_in),
        .load       (load),
        .load_ack   (load_ack),
        .frame_done (frame_done),
        .an         (an),
        .seg        (seg)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, m_n);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        int pre, c, d;
        bit wrap;
        if (reset) begin
            m_n = 0;
            m_pending = 0;
            for (int k = 0; k < N; k++) begin
                m_stag[k] = 7'h7F;
                m_shad[k] = 7'h7F;
            end
            e_an = 4'hF; e_seg = 7'h7F; e_ack = 1'b0; e_fd = 1'b0;
        end else begin
            pre  = m_n;
            c    = pre % R;
            d    = (pre / R) % N;
            wrap = (pre % F) == F - 1;
            e_an  = (c < G) ? 4'hF : ~(4'b0001 << d);
            e_seg = (c < G) ? 7'h7F : m_shad[d];
            e_fd  = wrap;
            e_ack = wrap && m_pending;
            if (e_ack) begin
                for (int k = 0; k < N; k++) m_shad[k] = m_stag[k];
            end
            if (load) begin
                for (int k = 0; k < N; k++) m_stag[k] = seg_in[7*k +: 7];
                m_pending = 1;
            end else if (e_ack) begin
                m_pending = 0;
            end
            m_n++;
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check("an", 32'(an), 32'(e_an));
        check("seg", 32'(seg), 32'(e_seg));
        check("load_ack", 32'(load_ack), 32'(e_ack));
        check("frame_done", 32'(frame_done), 32'(e_fd));
        check("an_at_most_one_low", 32'($countones(~an) <= 1), 32'd1);
        if (load_ack === 1'b1) ack_count++;
        $display("cyc=%0d reset=%0b load=%0b an=%b seg=%h ack=%0b fd=%0b",
                 m_n, reset, load, an, seg, load_ack, frame_done);
    endtask

    // Observe one full frame and record what each digit actually showed.
    task automatic capture_frame();
        for (int k = 0; k < N; k++) cap[k] = 'x;
        for (int i = 0; i < F; i++) begin
            step();
            for (int k = 0; k < N; k++) begin
                if (an == ~(4'b0001 << k)) cap[k] = seg;
            end
            if (an != 4'hF && (seg == 7'h30 || seg == 7'h19)) bad_seen++;
        end
    endtask

    task automatic align_to(input int phase);
        for (int i = 0; i < F && (m_n % F) != phase; i++) step();
    endtask

    initial begin
        int first_ack;

        tbl[0] = '{1,  4'hF, 7'h7F, 1'b0};
        tbl[1] = '{2,  4'hE, 7'h7F, 1'b0};
        tbl[2] = '{4,  4'hE, 7'h7F, 1'b0};
        tbl[3] = '{5,  4'hF, 7'h7F, 1'b0};
        tbl[4] = '{6,  4'hD, 7'h7F, 1'b0};
        tbl[5] = '{10, 4'hB, 7'h7F, 1'b0};
        tbl[6] = '{14, 4'h7, 7'h7F, 1'b0};
        tbl[7] = '{16, 4'h7, 7'h7F, 1'b1};
        tbl[8] = '{17, 4'hF, 7'h7F, 1'b0};
        tbl[9] = '{18, 4'hE, 7'h7F, 1'b0};

        // 1. reset, then blank scan with known anode/frame_done timing
        reset = 1'b1;
        repeat (3) step();
        check("reset_an", 32'(an), 32'hF);
        check("reset_seg", 32'(seg), 32'h7F);
        reset = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            step();
            foreach (tbl[i]) begin
                if (tbl[i].k == k) begin
                    check("t1_an", 32'(an), 32'(tbl[i].an));
                    check("t1_seg", 32'(seg), 32'(tbl[i].seg));
                    check("t1_fd", 32'(frame_done), 32'(tbl[i].fd));
                end
            end
        end

        // 2. single load commits at the next wrap
        seg_in = {7'h40, 7'h79, 7'h24, 7'h30};
        load = 1'b1;
        ack_count = 0;
        step();
        load = 1'b0;
        repeat (20) step();
        check("t2_ack_once", 32'(ack_count), 32'd1);
        capture_frame();
        check("t2_digit0", 32'(cap[0]), 32'h30);
        check("t2_digit1", 32'(cap[1]), 32'h24);
        check("t2_digit2", 32'(cap[2]), 32'h79);
        check("t2_digit3", 32'(cap[3]), 32'h40);

        // 3. three loads within one frame: last wins, single ack
        align_to(2);
        ack_count = 0;
        seg_in = {7'h40, 7'h79, 7'h24, 7'h30}; load = 1'b1; step();
        load = 1'b0; step();
        seg_in = {7'h40, 7'h79, 7'h24, 7'h19}; load = 1'b1; step();
        load = 1'b0; step();
        seg_in = {7'h40, 7'h79, 7'h24, 7'h12}; load = 1'b1; step();
        load = 1'b0;
        repeat (24) step();
        check("t3_single_ack", 32'(ack_count), 32'd1);
        bad_seen = 0;
        capture_frame();
        check("t3_digit0", 32'(cap[0]), 32'h12);
        check("t3_no_stale", 32'(bad_seen), 32'd0);

        // 4. load on the wrap cycle with nothing pending: ack one frame later
        align_to(F - 1);
        seg_in = {7'h00, 7'h12, 7'h19, 7'h08};
        load = 1'b1;
        step();
        load = 1'b0;
        first_ack = -1;
        for (int i = 1; i <= 24; i++) begin
            step();
            if (load_ack === 1'b1 && first_ack < 0) first_ack = i;
        end
        check("t4_ack_delay", 32'(first_ack), 32'd16);
        capture_frame();
        check("t4_digit0", 32'(cap[0]), 32'h08);
        check("t4_digit3", 32'(cap[3]), 32'h00);

        // 6. reset mid-frame with a pending frame
        align_to(5);
        seg_in = {7'h24, 7'h24, 7'h24, 7'h24};
        load = 1'b1;
        step();
        load = 1'b0;
        repeat (2) step();
        reset = 1'b1;
        step();
        check("t6_an_blank", 32'(an), 32'hF);
        check("t6_seg_blank", 32'(seg), 32'h7F);
        reset = 1'b0;
        ack_count = 0;
        repeat (40) step();
        check("t6_no_ack", 32'(ack_count), 32'd0);
        capture_frame();
        for (int k = 0; k < N; k++) check("t6_blank_digit", 32'(cap[k]), 32'h7F);

        // randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            load   = ($urandom_range(0, 5) == 0);
            seg_in = 28'($urandom);
            reset  = ($urandom_range(0, 199) == 0);
            step();
        end
        load = 1'b0;
        reset = 1'b0;
        repeat (F) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
